// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer (valid/ready on both sides).
// Optional macro IMM_EXT_BRANCH_EN: mode 11 yields a branch offset; otherwise it is sign-extended and flagged.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  num,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] res,
    output logic             mode_err
);
    // Handshake: a beat moves when valid && ready on that side; valid never waits on ready,
    // and res/mode_err hold while out_valid && !out_ready.

    // Encoding chosen so out_valid = state[0] and in_ready = !state[1] come straight from flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } buf_state_t;

    buf_state_t buf_state, buf_state_nxt;

    logic             accept;
    logic             load_out_new;
    logic             load_out_skid;
    logic             load_skid;
    logic [OUT_W-1:0] ext_val;
    logic             ext_err;
    logic [OUT_W-1:0] zx_val;
    logic [OUT_W-1:0] sx_val;
    logic [OUT_W-1:0] up_val;
    logic [OUT_W-1:0] skid_res;
    logic             skid_err;

    assign out_valid = buf_state[0];
    assign in_ready  = ~buf_state[1];
    assign accept    = in_valid & in_ready;

    assign zx_val = {{(OUT_W-IN_W){1'b0}}, num};
    assign sx_val = {{(OUT_W-IN_W){num[IN_W-1]}}, num};
    assign up_val = zx_val << IN_W;

`ifdef IMM_EXT_BRANCH_EN
    logic [OUT_W-1:0] br_val;
    assign br_val = sx_val << 2;
`endif

    always_comb begin
        ext_val = zx_val;
        ext_err = 1'b0;
        case (mode)
            2'b00: ext_val = zx_val;
            2'b01: ext_val = sx_val;
            2'b10: ext_val = up_val;
            default: begin
`ifdef IMM_EXT_BRANCH_EN
                ext_val = br_val;
`else
                ext_val = sx_val;
                ext_err = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) buf_state <= EMPTY;
        else     buf_state <= buf_state_nxt;
    end

    always_comb begin
        buf_state_nxt = buf_state;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (buf_state)
            EMPTY: begin
                if (accept) begin
                    buf_state_nxt = ONE;
                    load_out_new  = 1'b1;
                end
            end
            ONE: begin
                if (accept && out_ready) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
                    buf_state_nxt = FULL;
                    load_skid     = 1'b1;
                end else if (out_ready) begin
                    buf_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    buf_state_nxt = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: buf_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res      <= '0;
            mode_err <= 1'b0;
            skid_res <= '0;
            skid_err <= 1'b0;
        end else begin
            if (load_out_new) begin
                res      <= ext_val;
                mode_err <= ext_err;
            end else if (load_out_skid) begin
                res      <= skid_res;
                mode_err <= skid_err;
            end
            if (load_skid) begin
                skid_res <= ext_val;
                skid_err <= ext_err;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: 16->32 instance for all scenarios, 12->24 instance for width scaling.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, mode_err;
    logic [15:0] num;
    logic [1:0]  mode;
    logic [31:0] res;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, mode_err2;
    logic [11:0] num2;
    logic [1:0]  mode2;
    logic [23:0] res2;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .num(num), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .mode_err(mode_err)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(24)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .num(num2), .mode(mode2),
        .out_valid(out_valid2), .out_ready(out_ready2), .res(res2), .mode_err(mode_err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the stage empty; sends one item and sees it appear then drain.
    task automatic single(input string tag, input logic [15:0] n, input logic [1:0] m,
                          input logic [31:0] exp, input logic exp_err);
        in_valid  = 1'b1;
        num       = n;
        mode      = m;
        out_ready = 1'b1;
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_res"}, res, exp);
        check({tag, "_err"}, {31'b0, mode_err}, {31'b0, exp_err});
        @(negedge clk);
        check({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; num = '0; mode = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; num2 = '0; mode2 = '0; out_ready2 = 1'b1;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_err", {31'b0, mode_err}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Extension modes
        single("sign_neg", 16'h8001, 2'b01, 32'hFFFF8001, 1'b0);
        single("sign_pos", 16'h7FFF, 2'b01, 32'h00007FFF, 1'b0);
        single("zero", 16'h8001, 2'b00, 32'h00008001, 1'b0);
        single("upper", 16'h1234, 2'b10, 32'h12340000, 1'b0);
`ifdef IMM_EXT_BRANCH_EN
        single("branch", 16'hFFFF, 2'b11, 32'hFFFFFFFC, 1'b0);
`else
        single("branch", 16'hFFFF, 2'b11, 32'hFFFFFFFF, 1'b1);
`endif

        // Backpressure: A, B accepted, C held until draining starts
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'b01; num = 16'h0001;
        @(negedge clk);
        check("bp_a_valid", {31'b0, out_valid}, 32'd1);
        check("bp_a_res", res, 32'h00000001);
        check("bp_ready_after_a", {31'b0, in_ready}, 32'd1);
        num = 16'h0002;
        @(negedge clk);
        check("bp_ready_after_b", {31'b0, in_ready}, 32'd0);
        check("bp_hold_1", res, 32'h00000001);
        num = 16'h0003;
        @(negedge clk);
        check("bp_ready_stall", {31'b0, in_ready}, 32'd0);
        check("bp_hold_2", res, 32'h00000001);
        check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_b_valid", {31'b0, out_valid}, 32'd1);
        check("bp_b_res", res, 32'h00000002);
        check("bp_ready_drain", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_c_valid", {31'b0, out_valid}, 32'd1);
        check("bp_c_res", res, 32'h00000003);
        @(negedge clk);
        check("bp_empty", {31'b0, out_valid}, 32'd0);

        // Full throughput: one result per cycle, in order
        out_ready = 1'b1; mode = 2'b00;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            num = 16'(16'h00A0 + i);
            exp_q.push_back(32'(32'h000000A0 + i));
            check("tput_in_ready", {31'b0, in_ready}, 32'd1);
            @(negedge clk);
            check("tput_valid", {31'b0, out_valid}, 32'd1);
            check("tput_res", res, exp_q.pop_front());
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("tput_empty", {31'b0, out_valid}, 32'd0);

        // Reset with the buffer full
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'b01; num = 16'h0011;
        @(negedge clk);
        num = 16'h0022;
        @(negedge clk);
        in_valid = 1'b0;
        check("full_before_rst", {31'b0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_res", res, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        single("after_rst", 16'h0055, 2'b00, 32'h00000055, 1'b0);

        // Narrow instance 12->24
        in_valid2 = 1'b1; num2 = 12'h800; mode2 = 2'b01;
        @(negedge clk);
        in_valid2 = 1'b0;
        check("w12_valid", {31'b0, out_valid2}, 32'd1);
        check("w12_sign", {8'b0, res2}, 32'h00FFF800);
        check("w12_err", {31'b0, mode_err2}, 32'd0);
        @(negedge clk);
        check("w12_drained", {31'b0, out_valid2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
